// File: rtl/pipe_hazard_unit_pkg.sv
// Shared definitions for the ID-stage hazard/forwarding producer.
// Holds forwarding select codes, the stage record layout and the operand select function.
package pipe_hazard_unit_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF       = 2'b00;
    localparam logic [1:0] FWD_EXE_ALU  = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU  = 2'b10;
    localparam logic [1:0] FWD_MEM_LOAD = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rn;
        logic             wreg;
        logic             m2reg;
    } stage_rec_t;

    // The write flags already exclude $zero, so no separate register-0 test is needed.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] r,
        input logic             use_r,
        input logic             lu,
        input logic             ew,
        input logic             el,
        input logic [REG_W-1:0] er,
        input logic             mw,
        input logic             ml,
        input logic [REG_W-1:0] mr
    );
        if (!use_r || lu)            return FWD_RF;
        if (ew && !el && er == r)    return FWD_EXE_ALU;
        if (mw && mr == r)           return ml ? FWD_MEM_LOAD : FWD_MEM_ALU;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_stage_reg.sv
// One pipeline stage record with a freeze (hold) and a bubble (clear) control.
module hazard_stage_reg
    import pipe_hazard_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       clear,
    input  stage_rec_t d,
    output stage_rec_t q
);

    // Hold beats clear so a frozen pipeline never loses its in-flight record.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      q <= '0;
        else if (!hold)  q <= clear ? stage_rec_t'('0) : d;
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Tracks EXE/MEM destination info, drives forwarding selects, load-use stall/bubble,
// memory-busy freeze and a saturating stall-cycle counter.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic [4:0]             id_rn,
    input  logic                   id_write_regfile,
    input  logic                   id_mem_to_regfile,
    input  logic                   mem_busy,
    output logic [4:0]             exe_reg,
    output logic [4:0]             mem_reg,
    output logic                   exe_write_regfile,
    output logic                   mem_write_regfile,
    output logic                   exe_mem_to_regfile,
    output logic                   mem_mem_to_regfile,
    output logic [1:0]             fwda,
    output logic [1:0]             fwdb,
    output logic                   stall,
    output logic                   bubble,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

    stage_rec_t exe_q, mem_q, exe_d;
    logic       lu_a, lu_b, load_use;

    assign exe_d = '{valid: id_valid,
                     rn:    id_rn,
                     wreg:  id_write_regfile & id_valid,
                     m2reg: id_mem_to_regfile & id_valid};

    hazard_stage_reg u_exe (
        .clk(clk), .reset(reset), .hold(mem_busy), .clear(load_use), .d(exe_d), .q(exe_q)
    );

    hazard_stage_reg u_mem (
        .clk(clk), .reset(reset), .hold(mem_busy), .clear(1'b0), .d(exe_q), .q(mem_q)
    );

    assign exe_reg            = exe_q.rn;
    assign mem_reg            = mem_q.rn;
    assign exe_write_regfile  = exe_q.valid & exe_q.wreg & (exe_q.rn != '0);
    assign mem_write_regfile  = mem_q.valid & mem_q.wreg & (mem_q.rn != '0);
    assign exe_mem_to_regfile = exe_q.valid & exe_q.m2reg;
    assign mem_mem_to_regfile = mem_q.valid & mem_q.m2reg;

    assign lu_a = id_valid & exe_mem_to_regfile & exe_write_regfile & id_use_rs & (exe_reg == id_rs);
    assign lu_b = id_valid & exe_mem_to_regfile & exe_write_regfile & id_use_rt & (exe_reg == id_rt);
    assign load_use = lu_a | lu_b;

    assign fwda = fwd_sel(id_rs, id_use_rs, lu_a, exe_write_regfile, exe_mem_to_regfile, exe_reg,
                          mem_write_regfile, mem_mem_to_regfile, mem_reg);
    assign fwdb = fwd_sel(id_rt, id_use_rt, lu_b, exe_write_regfile, exe_mem_to_regfile, exe_reg,
                          mem_write_regfile, mem_mem_to_regfile, mem_reg);

    // mem_busy is an external input, so gate it to keep stall low while in reset.
    assign stall  = reset & (load_use | mem_busy);
    assign bubble = load_use & ~mem_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         stall_cnt <= '0;
        else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + CNT_ONE;
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Producer side of the hazard/forwarding interface consumed by the ID stage of the 5-stage MIPS pipeline.
- Tracks the destination register and write/load attributes of instructions in EXE and MEM. Drives exe_reg/mem_reg and the write/load flags to ID.
- Computes 2-bit forwarding selects for rs/rt (qa/qb) and generates the load-use stall/bubble and memory-busy freeze.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- STALL_CNT_W, 32, width of saturating stall counter

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  inst[25:21] of ID instruction
- id_rt  in  5  inst[20:16] of ID instruction
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_rn  in  5  destination register chosen by ID
- id_write_regfile  in  1  ID instruction writes regfile
- id_mem_to_regfile  in  1  ID instruction is a load
- mem_busy  in  1  data memory not ready; freeze whole pipeline
- exe_reg  out  5  EXE destination register
- mem_reg  out  5  MEM destination register
- exe_write_regfile  out  1  EXE valid, writes regfile, dest != 0
- mem_write_regfile  out  1  MEM valid, writes regfile, dest != 0
- exe_mem_to_regfile  out  1  EXE is a valid load
- mem_mem_to_regfile  out  1  MEM is a valid load
- fwda  out  2  forwarding select for qa
- fwdb  out  2  forwarding select for qb
- stall  out  1  hold PC and IF/ID register
- bubble  out  1  inject NOP into ID/EXE register
- stall_cnt  out  STALL_CNT_W  cycles with stall=1, saturating

Behaviour:
- Internal state: two stage records {valid, rn[4:0], wreg, m2reg}, EXE and MEM, plus stall_cnt.
- Reset (reset=0, async): both records cleared to valid=0, rn=0, wreg=0, m2reg=0; stall_cnt=0.
  - All outputs are 0 during reset: fwda=fwdb=00, stall=0, bubble=0.
- Forward select per operand (shown for rs; rt is identical with id_rt/id_use_rt):
  - 01 (EXE ALU result): exe_write_regfile & !exe_mem_to_regfile & exe_reg==id_rs.
  - Else 10 (MEM ALU result): mem_write_regfile & !mem_m2reg & mem_reg==id_rs.
  - Else 11 (MEM load data): mem_write_regfile & mem_m2reg & mem_reg==id_rs.
  - Else 00 (regfile). EXE takes priority over MEM.
  - Register 0 never forwards; use flag low gives 00.
  - The regfile is write-through, so the WB stage is not tracked.
- load_use = id_valid & exe_mem_to_regfile & exe_write_regfile & ((id_use_rs & exe_reg==id_rs) | (id_use_rt & exe_reg==id_rt)).
  - When load_use=1, the fwd select for the matching operand is don't-care; it is driven 00.
- stall = load_use | mem_busy (combinational).
- bubble = load_use & !mem_busy.
- On each rising edge:
  - mem_busy=1: EXE and MEM records hold. Freeze takes precedence over load_use.
  - mem_busy=0, load_use=1: MEM<=EXE; EXE<=invalid (bubble). The ID instruction is retried next cycle and then sees the load in MEM, giving fwd 11.
  - mem_busy=0, load_use=0: MEM<=EXE; EXE<={id_valid, id_rn, id_write_regfile & id_valid, id_mem_to_regfile & id_valid}.
  - stall_cnt increments when stall=1 and saturates at all-ones.
- Latency: forwarding outputs are combinational from current state and ID inputs. Stage records update in 1 cycle.
- Boundaries:
  - rs==rt, both used, with an EXE match: fwda=fwdb=01.
  - id_valid=0: no load_use and no stall from ID, but forwarding selects are still computed.
  - Reset asserted mid-freeze clears all state immediately. Deassertion is synchronous to clk through an external synchronizer.

Decomposition:
- Shared package/header (global_define.vh): FWD_RF=2'b00, FWD_EXE_ALU=2'b01, FWD_MEM_ALU=2'b10, FWD_MEM_LOAD=2'b11; stage-record field widths.
- One sub-module, hazard_stage_reg: a single record register with hold and clear-to-bubble controls. It is instantiated twice (EXE, MEM).

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0. Release, then clock 3 idle cycles -> outputs stay 0.
- ALU back-to-back: issue addu $3 (wreg=1, rn=3), then ID uses rs=3 -> fwda=01. Next cycle, with the next instruction using rt=3 -> fwdb=10.
- Load-use: issue lw $5, then ID uses rs=5 -> stall=1, bubble=1 for exactly 1 cycle. Next cycle fwda=11, stall=0, stall_cnt=1.
- $zero: issue addu with rn=0, wreg=1, then ID reads rs=0 -> fwda=00, exe_write_regfile=0.
- Freeze: mem_busy=1 for 4 cycles with a load in EXE -> exe_reg/mem_reg unchanged, stall=1, bubble=0, stall_cnt +4. Load-use resolves after release.
- Priority and saturation: EXE and MEM both write $7 with ID rs=$7 -> fwda=01. Force stall_cnt near max with STALL_CNT_W=4 -> holds at 15.
